// File: rtl/mul8u_sched_pkg.sv
// Shared types and the round-robin pick helper for the 8x8 multiplier sharing scheduler.
package mul8u_sched_pkg;

  localparam int OPW    = 8;
  localparam int PRW    = 16;
  localparam int MAXREQ = 8;

  typedef logic [OPW-1:0] op_t;
  typedef logic [PRW-1:0] prod_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First asserted valid at or after ptr, wrapping modulo nreq (ptr < nreq <= MAXREQ).
  function automatic rr_pick_t rr_pick(input logic [MAXREQ-1:0] valid,
                                       input logic [2:0]        ptr,
                                       input int unsigned       nreq);
    rr_pick_t   r;
    logic [3:0] cand;
    r = '0;
    // Scan from the far end so the candidate closest to ptr is written last.
    for (int k = MAXREQ - 1; k >= 0; k--) begin
      cand = 4'(ptr) + 4'(k);
      if (cand >= 4'(nreq)) cand = cand - 4'(nreq);
      if ((k < int'(nreq)) && valid[cand[2:0]]) begin
        r.found = 1'b1;
        r.idx   = cand[2:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mul8u_rr_arb.sv
// Round-robin grant over NREQ requesters; the pointer moves past the winner only on accept.
module mul8u_rr_arb
  import mul8u_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_valid,
  input  logic            s1_adv,
  output logic [NREQ-1:0] req_ready,
  output logic            accept,
  output logic [IDW-1:0]  grant_id
);

  if (IDW != $clog2(NREQ)) begin : g_bad_idw
    $error("IDW must equal clog2(NREQ)");
  end

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  rr_pick_t       pick;

  always_comb begin
    pick      = rr_pick(8'(req_valid), 3'(rr_ptr_q), NREQ);
    grant_id  = IDW'(pick.idx);
    accept    = pick.found & s1_adv;
    req_ready = '0;
    if (accept) req_ready[grant_id] = 1'b1;
    rr_ptr_d = rr_ptr_q;
    if (accept) rr_ptr_d = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/mul8u_share_sched.sv
// Time-shares one external combinational 8x8 multiplier among NREQ requesters with ID-tagged results.
// Optional error monitor (exact vs. core product) enabled by MUL8U_SCHED_ERRMON_EN.
module mul8u_share_sched
  import mul8u_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*OPW-1:0] req_a,
  input  logic [NREQ*OPW-1:0] req_b,
  output logic [OPW-1:0]      mul_a,
  output logic [OPW-1:0]      mul_b,
  input  logic [PRW-1:0]      mul_o,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [PRW-1:0]      res_data,
  output logic [IDW-1:0]      res_id,
  output logic                busy
`ifdef MUL8U_SCHED_ERRMON_EN
  ,
  output logic [PRW-1:0]      err_abs,
  output logic [31:0]         err_acc,
  output logic [31:0]         err_cnt
`endif
);

  logic           s1_valid_q, s1_valid_d;
  op_t            s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [IDW-1:0] s1_id_q, s1_id_d;
  logic           res_valid_q, res_valid_d;
  prod_t          res_data_q, res_data_d;
  logic [IDW-1:0] res_id_q, res_id_d;

  logic           s2_adv, s1_adv, accept;
  logic [IDW-1:0] grant_id;

  assign s2_adv = !res_valid_q | res_ready;
  assign s1_adv = !s1_valid_q | s2_adv;

  mul8u_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .s1_adv    (s1_adv),
    .req_ready (req_ready),
    .accept    (accept),
    .grant_id  (grant_id)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_id_d    = s1_id_q;
    if (s1_adv) s1_valid_d = accept;
    if (accept) begin
      s1_a_d  = req_a[grant_id*OPW +: OPW];
      s1_b_d  = req_b[grant_id*OPW +: OPW];
      s1_id_d = grant_id;
    end
  end

  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    if (s2_adv) res_valid_d = s1_valid_q;
    if (s2_adv && s1_valid_q) begin
      res_data_d = mul_o;
      res_id_d   = s1_id_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_id_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_id_q     <= s1_id_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
    end
  end

  assign mul_a     = s1_a_q;
  assign mul_b     = s1_b_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign busy      = s1_valid_q | res_valid_q;

`ifdef MUL8U_SCHED_ERRMON_EN
  prod_t       exact, err_abs_q, err_abs_d;
  logic [31:0] err_acc_q, err_acc_d, err_cnt_q, err_cnt_d;
  logic [32:0] acc_sum;

  always_comb begin
    exact     = PRW'(s1_a_q) * PRW'(s1_b_q);
    err_abs_d = err_abs_q;
    if (s2_adv && s1_valid_q)
      err_abs_d = (exact >= mul_o) ? exact - mul_o : mul_o - exact;
    acc_sum   = 33'(err_acc_q) + 33'(err_abs_q);
    err_acc_d = err_acc_q;
    err_cnt_d = err_cnt_q;
    // Accumulate only what the consumer actually takes.
    if (res_valid_q && res_ready) begin
      err_acc_d = acc_sum[32] ? '1 : acc_sum[31:0];
      if (err_abs_q != '0) err_cnt_d = err_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_abs_q <= '0;
      err_acc_q <= '0;
      err_cnt_q <= '0;
    end else begin
      err_abs_q <= err_abs_d;
      err_acc_q <= err_acc_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_abs = err_abs_q;
  assign err_acc = err_acc_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_mul8u_share_sched.sv
// Directed + random bench for mul8u_share_sched against a queue-based transaction model.
module tb_mul8u_share_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*8-1:0] req_a, req_b;
  logic [7:0]        mul_a, mul_b;
  logic [15:0]       mul_o;
  logic              res_valid, res_ready;
  logic [15:0]       res_data;
  logic [IDW-1:0]    res_id;
  logic              busy;
`ifdef MUL8U_SCHED_ERRMON_EN
  logic [15:0]       err_abs;
  logic [31:0]       err_acc, err_cnt;
`endif

  bit err_mode = 1'b0;
  int n_chk = 0, n_fail = 0, cycle = 0;
  int m_ptr = 0, last_acc = -1;

  typedef struct {
    int id;
    int prod;
    int a;
    int b;
    int t;
  } item_t;
  item_t q[$];
  int    pops[$];
  int    pop_cyc[$];

  always #5 clk = ~clk;

  // Core stub: exact product, or exact-100 for 200x200 when err_mode is set.
  assign mul_o = 16'(mul_a) * 16'(mul_b)
               - ((err_mode && mul_a == 8'd200 && mul_b == 8'd200) ? 16'd100 : 16'd0);

  mul8u_share_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_o     (mul_o),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .busy      (busy)
`ifdef MUL8U_SCHED_ERRMON_EN
    ,
    .err_abs   (err_abs),
    .err_acc   (err_acc),
    .err_cnt   (err_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int core_model(int a, int b);
    if (err_mode && a == 200 && b == 200) return a * b - 100;
    return a * b;
  endfunction

  function automatic int m_pick(logic [NREQ-1:0] v, int ptr);
    for (int k = 0; k < NREQ; k++)
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic set_op(input int i, input int a, input int b);
    req_a[8*i +: 8] = 8'(a);
    req_b[8*i +: 8] = 8'(b);
  endtask

  // Compare this cycle's outputs against the model, then apply the handshakes the model predicts.
  task automatic settle();
    int              g, ia, ib;
    bit              can, rv;
    logic [NREQ-1:0] exp_rdy;
    #1;
    rv  = (q.size() > 0) && (cycle >= q[0].t + 2);
    can = !(q.size() == 2 && !res_ready);
    g   = m_pick(req_valid, m_ptr);
    exp_rdy = '0;
    if (can && g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    chk("res_valid", res_valid, rv);
    chk("busy", busy, q.size() > 0);
    if (rv) begin
      chk("res_data", res_data, q[0].prod);
      chk("res_id", res_id, q[0].id);
    end
    if (q.size() == 2 || (q.size() == 1 && q[0].t == cycle - 1)) begin
      chk("mul_a", mul_a, q[q.size()-1].a);
      chk("mul_b", mul_b, q[q.size()-1].b);
    end
    last_acc = -1;
    if (rv && res_ready) begin
      pops.push_back(q[0].id);
      pop_cyc.push_back(cycle);
      void'(q.pop_front());
    end
    if (exp_rdy != '0) begin
      ia = int'(req_a[8*g +: 8]);
      ib = int'(req_b[8*g +: 8]);
      q.push_back('{id: g, prod: core_model(ia, ib), a: ia, b: ib, t: cycle});
      m_ptr    = (g + 1) % NREQ;
      last_acc = g;
    end
  endtask

  task automatic adv();
    @(negedge clk);
    cycle++;
  endtask

  task automatic step();
    settle();
    adv();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    q.delete();
    m_ptr = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    rst_n = 1'b1; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request, 12*10, latency 2
    set_op(0, 12, 10); req_valid = 4'b0001;
    step();
    req_valid = '0;
    step();
    settle();
    chk("t1_valid", res_valid, 1);
    chk("t1_data", res_data, 120);
    chk("t1_id", res_id, 0);
    adv();
    repeat (2) step();

    // All requesters continuously valid
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, $urandom_range(0, 255), $urandom_range(0, 255));
    req_valid = '1; pops.delete(); pop_cyc.delete(); start = cycle;
    for (int c = 0; c < 8; c++) begin
      settle(); adv();
      if (last_acc >= 0) set_op(last_acc, $urandom_range(0, 255), $urandom_range(0, 255));
    end
    req_valid = '0;
    repeat (3) step();
    chk("t2_npops", pops.size() >= 6, 1);
    for (int k = 0; k < 6; k++) begin
      if (k < pops.size()) begin
        chk("t2_id_seq", pops[k], k % NREQ);
        chk("t2_pop_cycle", pop_cyc[k], start + 2 + k);
      end
    end

    // Backpressure with 255*255
    res_ready = 1'b1; set_op(2, 255, 255); req_valid = 4'b0100;
    step();
    set_op(0, 3, 5); set_op(1, 7, 9); req_valid = 4'b0011; res_ready = 1'b0;
    settle();
    chk("t3_absorb", req_ready, 4'b0001);
    adv();
    req_valid = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("t3_hold_data", res_data, 65025);
      chk("t3_hold_rdy", req_ready, 0);
      chk("t3_hold_mula", mul_a, 3);
      adv();
    end
    res_ready = 1'b1;
    step();
    req_valid = '0;
    settle();
    chk("t3_next_data", res_data, 15);
    chk("t3_next_id", res_id, 0);
    adv();
    repeat (3) step();

    // Pointer at 2, requesters 1 and 3
    do_reset();
    set_op(1, 4, 4); req_valid = 4'b0010;
    step();
    req_valid = '0;
    repeat (3) step();
    set_op(1, 9, 11); set_op(3, 13, 17); req_valid = 4'b1010;
    settle(); chk("t4_first", req_ready, 4'b1000); adv();
    req_valid = 4'b0010;
    settle(); chk("t4_second", req_ready, 4'b0010); adv();
    set_op(0, 1, 2); set_op(2, 5, 6); req_valid = 4'b1111;
    settle(); chk("t4_ptr_end", req_ready, 4'b0100); adv();
    req_valid = '0;
    repeat (4) step();

    // Random traffic with random backpressure
    for (int c = 0; c < 300; c++) begin
      if (last_acc >= 0) req_valid[last_acc] = 1'($urandom_range(0, 1));
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          set_op(i, $urandom_range(0, 255), $urandom_range(0, 255));
          req_valid[i] = 1'b1;
        end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
      settle(); adv();
    end
    req_valid = '0; res_ready = 1'b1;
    repeat (4) step();

    // Reset with both stages full
    for (int i = 0; i < NREQ; i++) set_op(i, i + 20, i + 30);
    req_valid = '1; res_ready = 1'b0;
    repeat (3) step();
    chk("t5_full", q.size(), 2);
    req_valid = '0; rst_n = 1'b0;
    #1;
    chk("t5_rst_res_valid", res_valid, 0);
    chk("t5_rst_busy", busy, 0);
    q.delete(); m_ptr = 0;
    @(negedge clk);
    rst_n = 1'b1; res_ready = 1'b1;
    repeat (3) step();
    req_valid = '1;
    settle(); chk("t5_grant0", req_ready, 4'b0001); adv();
    req_valid = '0;
    repeat (3) step();

`ifdef MUL8U_SCHED_ERRMON_EN
    do_reset();
    err_mode = 1'b1;
    set_op(0, 200, 200); req_valid = 4'b0001;
    step();
    req_valid = '0;
    step();
    settle();
    chk("em_data", res_data, 39900);
    chk("em_err_abs", err_abs, 100);
    adv();
    settle();
    chk("em_err_acc", err_acc, 100);
    chk("em_err_cnt", err_cnt, 1);
    adv();
    err_mode = 1'b0;
    repeat (2) step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
